write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer_pkg.sv | 13 +
 rtl/write_buffer_array.sv | 77 +++++++
 rtl/write_buffer.sv | 108 ++++++++++
 tb/tb_write_buffer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/write_buffer_pkg.sv
// Shared LC-3b memory types and the write-buffer drain state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_pmem_line;
  typedef logic [11:0]  lc3b_line_addr;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_e;

endpackage

// File: rtl/write_buffer_array.sv
// Victim-line storage: entries, valid bits, line-address match for lookup and
// coalescing, with the newest matching entry taking priority.
module write_buffer_array
  import lc3b_types::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_alloc,
  input  logic [AW-1:0] wr_idx,
  input  lc3b_line_addr wr_line,
  input  lc3b_pmem_line wr_data,
  input  logic          pop_en,
  input  logic [AW-1:0] head_idx,
  input  logic          head_busy,
  input  lc3b_line_addr probe_line,
  output logic          coal_hit,
  output logic [AW-1:0] coal_idx,
  input  lc3b_line_addr lookup_line,
  output logic          lookup_hit,
  output lc3b_pmem_line lookup_data,
  output lc3b_line_addr head_line,
  output lc3b_pmem_line head_data
);

  lc3b_line_addr    line_q [DEPTH];
  lc3b_pmem_line    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    scan_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (pop_en)
        valid_q[head_idx] <= 1'b0;
      if (wr_en && wr_alloc)
        valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_q[wr_idx] <= wr_line;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Scan oldest to newest from the head so a later match overrides an earlier one.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    coal_hit    = 1'b0;
    coal_idx    = '0;
    scan_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_idx + AW'(i);
      if (valid_q[scan_idx] && line_q[scan_idx] == lookup_line) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[scan_idx];
      end
      // The head being written to pmem must stay stable, so it cannot absorb a push.
      if (valid_q[scan_idx] && line_q[scan_idx] == probe_line &&
          !(head_busy && scan_idx == head_idx)) begin
        coal_hit = 1'b1;
        coal_idx = scan_idx;
      end
    end
  end

  assign head_line = line_q[head_idx];
  assign head_data = data_q[head_idx];

endmodule

// File: rtl/write_buffer.sv
// Write-back victim buffer: circular FIFO of dirty lines drained one at a time to pmem.
//   state    | meaning
//   WB_IDLE  | no pmem write outstanding; start one when entries exist and not inhibited
//   WB_WRITE | pmem_write held on head entry until pmem_resp pops it
module write_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_req,
  input  logic [15:0]   wb_addr,
  input  logic [127:0]  wb_data,
  output logic          wb_ready,
  output logic          wb_empty,
  input  logic [15:0]   lookup_addr,
  output logic          lookup_hit,
  output logic [127:0]  lookup_data,
  input  logic          drain_inhibit,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  output logic          pmem_write,
  input  logic          pmem_resp
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_state_e     state_q, state_d;
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic          coal_hit;
  logic [AW-1:0] coal_idx;
  logic          push, coalesce, pop;
  lc3b_line_addr head_line;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{wb_addr[3:0], lookup_addr[3:0]};

  assign wb_ready = (count_q < CW'(DEPTH));
  assign wb_empty = (count_q == '0) && (state_q == WB_IDLE);
  assign coalesce = wb_req && coal_hit;
  assign push     = wb_req && !coal_hit && wb_ready;
  assign pop      = (state_q == WB_WRITE) && pmem_resp;

  always_comb begin
    state_d    = state_q;
    pmem_write = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (count_q != '0 && !drain_inhibit)
          state_d = WB_WRITE;
      end
      WB_WRITE: begin
        pmem_write = 1'b1;
        if (pmem_resp)
          state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WB_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push)
        tail_q <= tail_q + 1'b1;
      if (pop)
        head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  write_buffer_array #(.DEPTH(DEPTH)) u_array (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (push || coalesce),
    .wr_alloc    (push),
    .wr_idx      (coal_hit ? coal_idx : tail_q),
    .wr_line     (wb_addr[15:4]),
    .wr_data     (wb_data),
    .pop_en      (pop),
    .head_idx    (head_q),
    .head_busy   (state_q == WB_WRITE),
    .probe_line  (wb_addr[15:4]),
    .coal_hit    (coal_hit),
    .coal_idx    (coal_idx),
    .lookup_line (lookup_addr[15:4]),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .head_line   (head_line),
    .head_data   (pmem_wdata)
  );

  assign pmem_address = {head_line, 4'h0};

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: a table of per-cycle vectors plus hand-written
// sequences for write-in-flight reallocation, full-buffer pop/push and reset mid-write.
module tb_write_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         wb_req;
  logic [15:0]  wb_addr;
  logic [127:0] wb_data;
  logic         wb_ready;
  logic         wb_empty;
  logic [15:0]  lookup_addr;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic         drain_inhibit;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_write;
  logic         pmem_resp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_req        (wb_req),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_ready      (wb_ready),
    .wb_empty      (wb_empty),
    .lookup_addr   (lookup_addr),
    .lookup_hit    (lookup_hit),
    .lookup_data   (lookup_data),
    .drain_inhibit (drain_inhibit),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_write    (pmem_write),
    .pmem_resp     (pmem_resp)
  );

  localparam logic [127:0] Z  = '0;
  localparam logic [127:0] D0 = {16{8'hD0}};
  localparam logic [127:0] D1 = {16{8'hD1}};
  localparam logic [127:0] D2 = {16{8'hD2}};
  localparam logic [127:0] D3 = {16{8'hD3}};
  localparam logic [127:0] D9 = {16{8'hD9}};
  localparam logic [127:0] DA = {16{8'hAA}};
  localparam logic [127:0] DB = {16{8'hBB}};
  localparam logic [127:0] E1 = {16{8'hE1}};
  localparam logic [127:0] E2 = {16{8'hE2}};
  localparam logic [127:0] X7 = {16{8'h77}};

  typedef struct {
    logic         req;
    logic [15:0]  addr;
    logic [127:0] data;
    logic [15:0]  lk;
    logic         inh;
    logic         resp;
    logic         e_ready;
    logic         e_empty;
    logic         e_hit;
    logic [127:0] e_ldata;
    logic         e_pw;
    logic [15:0]  e_paddr;
    logic [127:0] e_pwdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic req, logic [15:0] addr, logic [127:0] data,
                              logic [15:0] lk, logic inh, logic resp,
                              logic e_ready, logic e_empty, logic e_hit,
                              logic [127:0] e_ldata, logic e_pw,
                              logic [15:0] e_paddr, logic [127:0] e_pwdata);
    vec_t v;
    v.req = req; v.addr = addr; v.data = data; v.lk = lk; v.inh = inh; v.resp = resp;
    v.e_ready = e_ready; v.e_empty = e_empty; v.e_hit = e_hit; v.e_ldata = e_ldata;
    v.e_pw = e_pw; v.e_paddr = e_paddr; v.e_pwdata = e_pwdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [15:0] addr, input logic [127:0] data,
                       input logic [15:0] lk, input logic inh, input logic resp);
    wb_req = req; wb_addr = addr; wb_data = data;
    lookup_addr = lk; drain_inhibit = inh; pmem_resp = resp;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 16'h0, Z, 16'h1238, 1'b1, 1'b0);
    step();
    @(negedge clk);
    chk("rst_ready", wb_ready, 1'b1);
    chk("rst_empty", wb_empty, 1'b1);
    chk("rst_hit",   lookup_hit, 1'b0);
    chk("rst_pw",    pmem_write, 1'b0);
    step();
    reset = 1'b0;

    // single push, inhibited, then 5-cycle drain; then fill, drop, coalesce, drain
    vecs.push_back(mk(0, 16'h0000, Z,  16'h1238, 1, 0, 1, 1, 0, Z,  0, 16'h0000, Z));
    vecs.push_back(mk(1, 16'h1230, D0, 16'h1238, 1, 0, 1, 1, 0, Z,  0, 16'h0000, Z));
    vecs.push_back(mk(0, 16'h0000, Z,  16'h1238, 1, 0, 1, 0, 1, D0, 0, 16'h0000, Z));
    vecs.push_back(mk(0, 16'h0000, Z,  16'h1238, 0, 0, 1, 0, 1, D0, 0, 16'h0000, Z));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 16'h0000, Z, 16'h1238, 0, 0, 1, 0, 1, D0, 1, 16'h1230, D0));
    vecs.push_back(mk(0, 16'h0000, Z,  16'h1238, 0, 1, 1, 0, 1, D0, 1, 16'h1230, D0));
    vecs.push_back(mk(0, 16'h0000, Z,  16'h1238, 1, 0, 1, 1, 0, Z,  0, 16'h0000, Z));
    vecs.push_back(mk(1, 16'h1000, D1, 16'h1000, 1, 0, 1, 1, 0, Z,  0, 16'h0000, Z));
    vecs.push_back(mk(1, 16'h2000, D2, 16'h100C, 1, 0, 1, 0, 1, D1, 0, 16'h0000, Z));
    vecs.push_back(mk(1, 16'h3000, D3, 16'h3000, 1, 0, 0, 0, 0, Z,  0, 16'h0000, Z));
    vecs.push_back(mk(1, 16'h1000, D9, 16'h3000, 1, 0, 0, 0, 0, Z,  0, 16'h0000, Z));
    vecs.push_back(mk(0, 16'h0000, Z,  16'h1000, 0, 0, 0, 0, 1, D9, 0, 16'h0000, Z));
    vecs.push_back(mk(0, 16'h0000, Z,  16'h2000, 0, 1, 0, 0, 1, D2, 1, 16'h1000, D9));
    vecs.push_back(mk(0, 16'h0000, Z,  16'h1000, 0, 0, 1, 0, 0, Z,  0, 16'h0000, Z));
    vecs.push_back(mk(0, 16'h0000, Z,  16'h2000, 0, 1, 1, 0, 1, D2, 1, 16'h2000, D2));
    vecs.push_back(mk(0, 16'h0000, Z,  16'h2000, 1, 0, 1, 1, 0, Z,  0, 16'h0000, Z));

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].addr, vecs[i].data, vecs[i].lk, vecs[i].inh, vecs[i].resp);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), wb_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_empty", i), wb_empty, vecs[i].e_empty);
      chk($sformatf("v%0d_hit", i), lookup_hit, vecs[i].e_hit);
      if (vecs[i].e_hit)
        chk($sformatf("v%0d_ldata", i), lookup_data, vecs[i].e_ldata);
      chk($sformatf("v%0d_pw", i), pmem_write, vecs[i].e_pw);
      if (vecs[i].e_pw) begin
        chk($sformatf("v%0d_paddr", i), pmem_address, vecs[i].e_paddr);
        chk($sformatf("v%0d_pwdata", i), pmem_wdata, vecs[i].e_pwdata);
      end
      step();
    end

    // same line pushed while its older copy is being written
    drive(1'b1, 16'h4000, DA, 16'h4000, 1'b0, 1'b0);
    @(negedge clk); chk("rw_ready0", wb_ready, 1'b1);
    step();
    drive(1'b0, 16'h0000, Z, 16'h4000, 1'b0, 1'b0);
    @(negedge clk); chk("rw_pw_idle", pmem_write, 1'b0);
    step();
    drive(1'b1, 16'h4000, DB, 16'h4000, 1'b0, 1'b0);
    @(negedge clk);
    chk("rw_pw_a", pmem_write, 1'b1);
    chk("rw_wd_a", pmem_wdata, DA);
    chk("rw_ready1", wb_ready, 1'b1);
    step();
    drive(1'b0, 16'h0000, Z, 16'h4000, 1'b0, 1'b0);
    @(negedge clk);
    chk("rw_hit_b", lookup_hit, 1'b1);
    chk("rw_ld_b", lookup_data, DB);
    chk("rw_wd_hold", pmem_wdata, DA);
    chk("rw_ready_full", wb_ready, 1'b0);
    step();
    pmem_resp = 1'b1;
    @(negedge clk); chk("rw_wd_a_resp", pmem_wdata, DA);
    step();
    pmem_resp = 1'b0;
    @(negedge clk); chk("rw_gap", pmem_write, 1'b0);
    step();
    @(negedge clk);
    chk("rw_pw_b", pmem_write, 1'b1);
    chk("rw_pa_b", pmem_address, 16'h4000);
    chk("rw_wd_b", pmem_wdata, DB);
    pmem_resp = 1'b1;
    step();
    drive(1'b0, 16'h0000, Z, 16'h4000, 1'b1, 1'b0);
    @(negedge clk); chk("rw_empty", wb_empty, 1'b1);
    step();

    // full buffer: pop coincides with a push, then reset mid-write
    drive(1'b1, 16'h5000, E1, 16'h5000, 1'b1, 1'b0);
    step();
    drive(1'b1, 16'h6000, E2, 16'h5000, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0000, Z, 16'h5000, 1'b0, 1'b0);
    @(negedge clk); chk("fu_ready0", wb_ready, 1'b0);
    step();
    drive(1'b1, 16'h7000, X7, 16'h5000, 1'b0, 1'b1);
    @(negedge clk);
    chk("fu_pw", pmem_write, 1'b1);
    chk("fu_pa", pmem_address, 16'h5000);
    chk("fu_ready_pop", wb_ready, 1'b0);
    step();
    drive(1'b0, 16'h0000, Z, 16'h7000, 1'b0, 1'b0);
    @(negedge clk);
    chk("fu_drop_hit", lookup_hit, 1'b0);
    chk("fu_ready1", wb_ready, 1'b1);
    chk("fu_empty", wb_empty, 1'b0);
    chk("fu_gap", pmem_write, 1'b0);
    step();
    lookup_addr = 16'h6000;
    @(negedge clk);
    chk("fu_pw2", pmem_write, 1'b1);
    chk("fu_pa2", pmem_address, 16'h6000);
    chk("fu_hit_e2", lookup_hit, 1'b1);
    chk("fu_ld_e2", lookup_data, E2);
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("rs_pw", pmem_write, 1'b0);
    chk("rs_empty", wb_empty, 1'b1);
    chk("rs_hit", lookup_hit, 1'b0);
    chk("rs_ready", wb_ready, 1'b1);
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
